// File: rtl/data_mem_dump_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_dump_sequencer_pkg
// Shared definitions for the DataMemory dump sequencer:
//   - FSM state encodings (3-bit, kept as plain localparams so older tools and
//     waveform viewers see stable numeric codes)
//   - helpers to size the byte serializer from the RAM word width
// -----------------------------------------------------------------------------
package data_mem_dump_sequencer_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RD   = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_SEND = 3'd3;
    localparam logic [2:0] ST_TXW  = 3'd4;
    localparam logic [2:0] ST_FIN  = 3'd5;

    // Number of bytes carried by one RAM word (DATA_W is a multiple of 8).
    function automatic int bytes_per_word(input int data_w);
        return data_w / 8;
    endfunction

    // Width of a byte index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/data_mem_dump_sequencer_word_byte_serializer.sv
// -----------------------------------------------------------------------------
// data_mem_dump_sequencer_word_byte_serializer
// Captures one RAM word and presents it one byte at a time, most significant
// byte first.
// Ports:
//   i_clk    clock
//   i_reset  asynchronous active-high reset (clears word and index)
//   i_load   capture i_word and restart at the most significant byte
//   i_word   word to capture
//   i_next   advance to the next (less significant) byte
//   o_byte   currently selected byte
//   o_last   the selected byte is the least significant one
// -----------------------------------------------------------------------------
module data_mem_dump_sequencer_word_byte_serializer
    import data_mem_dump_sequencer_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_word,
    input  logic              i_next,
    output logic [7:0]        o_byte,
    output logic              o_last
);
    localparam int BPW   = bytes_per_word(DATA_W);
    localparam int IDX_W = idx_width(BPW);

    logic [DATA_W-1:0] r_word_q;
    logic [IDX_W-1:0]  r_byte_idx;
    logic [7:0]        w_bytes [BPW];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_word_q   <= '0;
            r_byte_idx <= '0;
        end else if (i_load) begin
            r_word_q   <= i_word;
            r_byte_idx <= '0;
        end else if (i_next) begin
            r_byte_idx <= r_byte_idx + 1'b1;
        end
    end

    // Index 0 maps to the top byte so the index counts in transmit order.
    generate
        for (genvar gi = 0; gi < BPW; gi++) begin : g_byte_sel
            assign w_bytes[gi] = r_word_q[(BPW-1-gi)*8 +: 8];
        end
    endgenerate

    assign o_byte = w_bytes[r_byte_idx];
    assign o_last = (r_byte_idx == IDX_W'(BPW - 1));

endmodule

// File: rtl/data_mem_dump_sequencer.sv
// -----------------------------------------------------------------------------
// data_mem_dump_sequencer
// Arbitrates the single DataMemory port between the pipeline MEM stage and a
// debug dump path. When idle the pipeline's write enables and address pass
// straight through. A dump request with the datapath halted takes the port,
// reads words 0..NUM_WORDS-1 and streams each one MSB-first over the UART TX
// byte handshake, then hands the port back.
// Ports:
//   i_clk, i_reset          clock, asynchronous active-high reset
//   i_dump_start            1-cycle dump request (only honoured when idle and halted)
//   i_datapath_on           pipeline running; aborts a dump in progress
//   i_pipe_we, i_pipe_addr  MEM-stage byte write enables / word address
//   i_ram_dout              DataMemory read data (1-cycle latency)
//   i_tx_done               UART byte-sent pulse
//   o_ram_we, o_ram_addr    DataMemory byte write enables / address
//   o_tx_data, o_tx_start   byte to send and its 1-cycle start pulse
//   o_dbg_grant             debug path owns the RAM port
//   o_busy                  dump in progress
//   o_dump_done             1-cycle pulse: full dump completed
//   o_dump_abort            1-cycle pulse: dump abandoned because the datapath resumed
// -----------------------------------------------------------------------------
module data_mem_dump_sequencer
    import data_mem_dump_sequencer_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int NUM_WORDS = 256
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_dump_start,
    input  logic              i_datapath_on,
    input  logic [3:0]        i_pipe_we,
    input  logic [ADDR_W-1:0] i_pipe_addr,
    input  logic [DATA_W-1:0] i_ram_dout,
    input  logic              i_tx_done,
    output logic [3:0]        o_ram_we,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_start,
    output logic              o_dbg_grant,
    output logic              o_busy,
    output logic              o_dump_done,
    output logic              o_dump_abort
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

    logic [2:0]        r_state;
    logic [2:0]        w_state_next;
    logic [ADDR_W-1:0] r_word_addr;
    logic              r_abort_pend;
    logic              r_dump_abort;
    logic              w_abort_now;
    logic              w_addr_clr;
    logic              w_addr_inc;
    logic              w_load;
    logic              w_next;
    logic              w_last;
    logic [7:0]        w_byte;

    always_comb begin
        w_state_next = r_state;
        w_abort_now  = 1'b0;
        w_addr_clr   = 1'b0;
        w_addr_inc   = 1'b0;
        w_load       = 1'b0;
        w_next       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_dump_start && !i_datapath_on) begin
                    w_state_next = ST_RD;
                    w_addr_clr   = 1'b1;
                end
            end
            ST_RD: begin
                if (i_datapath_on) begin
                    w_state_next = ST_IDLE;
                    w_abort_now  = 1'b1;
                end else begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (i_datapath_on) begin
                    w_state_next = ST_IDLE;
                    w_abort_now  = 1'b1;
                end else begin
                    w_state_next = ST_SEND;
                    w_load       = 1'b1;
                end
            end
            ST_SEND: begin
                if (i_datapath_on) begin
                    w_state_next = ST_IDLE;
                    w_abort_now  = 1'b1;
                end else begin
                    w_state_next = ST_TXW;
                end
            end
            ST_TXW: begin
                // Never cut the UART mid-byte: a resume request seen at any
                // point in TXW is remembered and acted on at tx_done.
                if (i_tx_done) begin
                    if (i_datapath_on || r_abort_pend) begin
                        w_state_next = ST_IDLE;
                        w_abort_now  = 1'b1;
                    end else if (!w_last) begin
                        w_state_next = ST_SEND;
                        w_next       = 1'b1;
                    end else if (r_word_addr == LAST_ADDR) begin
                        w_state_next = ST_FIN;
                    end else begin
                        w_state_next = ST_RD;
                        w_addr_inc   = 1'b1;
                    end
                end
            end
            ST_FIN: begin
                w_state_next = ST_IDLE;
                w_addr_clr   = 1'b1;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_word_addr  <= '0;
            r_abort_pend <= 1'b0;
            r_dump_abort <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_dump_abort <= w_abort_now;
            if (w_addr_clr) begin
                r_word_addr <= '0;
            end else if (w_addr_inc) begin
                r_word_addr <= r_word_addr + 1'b1;
            end
            if (w_state_next == ST_IDLE) begin
                r_abort_pend <= 1'b0;
            end else if (r_state == ST_TXW && i_datapath_on) begin
                r_abort_pend <= 1'b1;
            end
        end
    end

    data_mem_dump_sequencer_word_byte_serializer #(
        .DATA_W (DATA_W)
    ) u_serializer (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_load  (w_load),
        .i_word  (i_ram_dout),
        .i_next  (w_next),
        .o_byte  (w_byte),
        .o_last  (w_last)
    );

    // Port mux: debug only ever reads, so its write enables are forced low.
    assign o_dbg_grant  = (r_state != ST_IDLE);
    assign o_busy       = (r_state != ST_IDLE);
    assign o_ram_we     = o_dbg_grant ? 4'b0000 : i_pipe_we;
    assign o_ram_addr   = o_dbg_grant ? r_word_addr : i_pipe_addr;
    assign o_tx_data    = w_byte;
    assign o_tx_start   = (r_state == ST_SEND);
    assign o_dump_done  = (r_state == ST_FIN);
    assign o_dump_abort = r_dump_abort;

endmodule

// File: tb/tb_data_mem_dump_sequencer.sv
module tb_data_mem_dump_sequencer;
    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 32;
    localparam int NUM_WORDS = 2;
    localparam int TX_DELAY  = 5;
    // 3 cycles to first byte, TX_DELAY per byte, 2 extra per word change.
    localparam int DUMP_CYCLES = 3 + NUM_WORDS * 4 * TX_DELAY + (NUM_WORDS - 1) * 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              dump_start;
    logic              datapath_on;
    logic [3:0]        pipe_we;
    logic [ADDR_W-1:0] pipe_addr;
    logic [DATA_W-1:0] ram_dout;
    logic              tx_done;
    logic              resp_done;
    logic              extra_done;
    logic [3:0]        ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        tx_data;
    logic              tx_start;
    logic              dbg_grant;
    logic              busy;
    logic              dump_done;
    logic              dump_abort;

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [7:0]        exp_q [$];
    int                checks = 0;
    int                errors = 0;
    int                tx_start_cnt = 0;
    bit                spur_send = 1'b0;

    always #5 clk = ~clk;

    assign tx_done = resp_done | extra_done;

    data_mem_dump_sequencer #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .NUM_WORDS (NUM_WORDS)
    ) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_dump_start  (dump_start),
        .i_datapath_on (datapath_on),
        .i_pipe_we     (pipe_we),
        .i_pipe_addr   (pipe_addr),
        .i_ram_dout    (ram_dout),
        .i_tx_done     (tx_done),
        .o_ram_we      (ram_we),
        .o_ram_addr    (ram_addr),
        .o_tx_data     (tx_data),
        .o_tx_start    (tx_start),
        .o_dbg_grant   (dbg_grant),
        .o_busy        (busy),
        .o_dump_done   (dump_done),
        .o_dump_abort  (dump_abort)
    );

    // DataMemory model: synchronous read, one cycle latency.
    always @(posedge clk) ram_dout <= mem[ram_addr];

    // UART responder: tx_done arrives TX_DELAY-1 cycles after the tx_start cycle.
    initial begin
        resp_done = 1'b0;
        forever begin
            @(negedge clk);
            resp_done = 1'b0;
            if (tx_start && !reset) begin
                if (spur_send) resp_done = 1'b1;
                @(negedge clk);
                resp_done = 1'b0;
                repeat (TX_DELAY - 2) @(negedge clk);
                resp_done = 1'b1;
            end
        end
    end

    // Scoreboard: every tx_start pops the next expected byte.
    always @(negedge clk) begin
        if (!reset && tx_start) begin
            tx_start_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL tx_byte: tx_start with data %h, required no transmission", tx_data);
            end else begin
                automatic logic [7:0] e = exp_q.pop_front();
                if (tx_data !== e) begin
                    errors++;
                    $display("FAIL tx_byte: tx_data %h, required %h", tx_data, e);
                end else begin
                    $display("tx byte %h ok", tx_data);
                end
            end
        end
    end

    // The pipeline must be halted whenever the debug path owns the port.
    always @(negedge clk) begin
        if (!reset && dbg_grant && pipe_we != 4'b0) begin
            errors++;
            $display("FAIL pipe_we_while_grant: pipe_we %h, required 0", pipe_we);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic run_dump(output int done_at);
        done_at = -1;
        @(negedge clk); dump_start = 1'b1;
        @(negedge clk); dump_start = 1'b0;
        for (int k = 1; k <= 600; k++) begin
            if (dump_done) begin
                done_at = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_tx_starts(input int n, output bit ok);
        int seen = 0;
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (tx_start) seen++;
            if (seen == n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({tx_start, busy, dbg_grant, dump_done, dump_abort} !== 5'b0 || tx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: flags %b data %h, required 00000 / 00",
                     {tx_start, busy, dbg_grant, dump_done, dump_abort}, tx_data);
        end
        checks++;
        if (ram_we !== 4'h3 || ram_addr !== 8'h5A) begin
            errors++;
            $display("FAIL reset_mux: ram_we %h ram_addr %h, required 3 / 5a", ram_we, ram_addr);
        end
        $display("reset state checked");
        @(negedge clk); pipe_we = 4'h0; reset = 1'b0;
    endtask

    task automatic test_passthrough();
        @(negedge clk);
        datapath_on = 1'b1; pipe_we = 4'hF; pipe_addr = 8'h12;
        @(negedge clk);
        checks++;
        if (ram_we !== 4'hF || ram_addr !== 8'h12 || dbg_grant !== 1'b0) begin
            errors++;
            $display("FAIL passthrough: ram_we %h ram_addr %h grant %b, required f / 12 / 0",
                     ram_we, ram_addr, dbg_grant);
        end
        dump_start = 1'b1;
        @(negedge clk); dump_start = 1'b0;
        repeat (3) begin
            checks++;
            if (busy !== 1'b0 || dbg_grant !== 1'b0 || dump_abort !== 1'b0) begin
                errors++;
                $display("FAIL start_ignored: busy %b grant %b abort %b, required 0 0 0",
                         busy, dbg_grant, dump_abort);
            end
            @(negedge clk);
        end
        $display("passthrough and ignored start checked");
        pipe_we = 4'h0; datapath_on = 1'b0;
    endtask

    task automatic test_first_byte_timing();
        int done_at = -1;
        exp_q = {8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        @(negedge clk); dump_start = 1'b1;
        @(negedge clk); dump_start = 1'b0;
        checks++;
        if (ram_addr !== 8'h00 || dbg_grant !== 1'b1 || ram_we !== 4'h0) begin
            errors++;
            $display("FAIL rd_cycle: ram_addr %h grant %b ram_we %h, required 00 / 1 / 0",
                     ram_addr, dbg_grant, ram_we);
        end
        for (int k = 1; k <= 600; k++) begin
            if (k <= 3) begin
                checks++;
                if (tx_start !== (k == 3)) begin
                    errors++;
                    $display("FAIL first_byte_timing: cycle %0d tx_start %b, required %b", k, tx_start, k == 3);
                end
            end
            if (dump_done) begin
                done_at = k;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (done_at != DUMP_CYCLES) begin
            errors++;
            $display("FAIL timing_done: dump_done at cycle %0d, required %0d", done_at, DUMP_CYCLES);
        end
        $display("first byte timing checked, done at %0d", done_at);
        @(negedge clk);
    endtask

    task automatic test_full_dump();
        int done_at;
        int cnt0 = tx_start_cnt;
        exp_q = {8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_dump(done_at);
        checks++;
        if (done_at != DUMP_CYCLES || dump_abort !== 1'b0) begin
            errors++;
            $display("FAIL full_dump_done: done at %0d abort %b, required %0d / 0", done_at, dump_abort, DUMP_CYCLES);
        end
        checks++;
        if (tx_start_cnt - cnt0 != 8 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL full_dump_count: %0d tx_starts, %0d bytes left, required 8 / 0",
                     tx_start_cnt - cnt0, exp_q.size());
        end
        @(negedge clk);
        checks++;
        if (dbg_grant !== 1'b0 || busy !== 1'b0 || dump_done !== 1'b0) begin
            errors++;
            $display("FAIL full_dump_release: grant %b busy %b done %b, required 0 0 0",
                     dbg_grant, busy, dump_done);
        end
        $display("full dump checked");
    endtask

    task automatic test_abort_in_rd();
        @(negedge clk); dump_start = 1'b1;
        @(negedge clk); dump_start = 1'b0; datapath_on = 1'b1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_rd_busy: busy %b, required 1", busy);
        end
        @(negedge clk);
        checks++;
        if (dump_abort !== 1'b1 || dbg_grant !== 1'b0 || dump_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_rd: abort %b grant %b done %b, required 1 0 0", dump_abort, dbg_grant, dump_done);
        end
        @(negedge clk);
        checks++;
        if (dump_abort !== 1'b0) begin
            errors++;
            $display("FAIL abort_rd_pulse: abort %b, required 0", dump_abort);
        end
        $display("abort in RD checked");
        datapath_on = 1'b0;
    endtask

    task automatic test_abort_in_txw();
        bit ok;
        int cnt0 = tx_start_cnt;
        exp_q = {8'h11, 8'h22};
        @(negedge clk); dump_start = 1'b1;
        @(negedge clk); dump_start = 1'b0;
        wait_tx_starts(1, ok);
        wait_tx_starts(1, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL abort_txw_setup: second tx_start seen %b, required 1", ok);
        end
        @(negedge clk); datapath_on = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || dump_abort !== 1'b0) begin
            errors++;
            $display("FAIL abort_txw_hold: busy %b abort %b, required 1 0", busy, dump_abort);
        end
        @(negedge clk);
        checks++;
        if (dump_abort !== 1'b1 || busy !== 1'b0 || dbg_grant !== 1'b0 || dump_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_txw: abort %b busy %b grant %b done %b, required 1 0 0 0",
                     dump_abort, busy, dbg_grant, dump_done);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (tx_start_cnt - cnt0 != 2 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL abort_txw_count: %0d tx_starts, %0d left, required 2 / 0",
                     tx_start_cnt - cnt0, exp_q.size());
        end
        $display("abort in TXW checked");
        datapath_on = 1'b0;
    endtask

    task automatic test_reset_mid_dump();
        bit ok;
        int done_at = -1;
        exp_q = {8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB};
        @(negedge clk); dump_start = 1'b1;
        @(negedge clk); dump_start = 1'b0;
        wait_tx_starts(6, ok);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (!ok || busy !== 1'b0 || dbg_grant !== 1'b0 || tx_start !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: reached %b busy %b grant %b tx_start %b, required 1 0 0 0",
                     ok, busy, dbg_grant, tx_start);
        end
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        exp_q = {8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        dump_start = 1'b1;
        @(negedge clk); dump_start = 1'b0;
        checks++;
        if (ram_addr !== 8'h00 || dbg_grant !== 1'b1) begin
            errors++;
            $display("FAIL restart_addr: ram_addr %h grant %b, required 00 / 1", ram_addr, dbg_grant);
        end
        for (int k = 1; k <= 600; k++) begin
            if (dump_done) begin
                done_at = k;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (done_at != DUMP_CYCLES || exp_q.size() != 0) begin
            errors++;
            $display("FAIL restart_dump: done at %0d, %0d left, required %0d / 0",
                     done_at, exp_q.size(), DUMP_CYCLES);
        end
        $display("reset mid dump checked");
        @(negedge clk);
    endtask

    task automatic test_spurious_tx_done();
        int done_at;
        int cnt0;
        @(negedge clk); extra_done = 1'b1;
        @(negedge clk); extra_done = 1'b0;
        checks++;
        if (busy !== 1'b0 || tx_start !== 1'b0) begin
            errors++;
            $display("FAIL spurious_idle: busy %b tx_start %b, required 0 0", busy, tx_start);
        end
        spur_send = 1'b1;
        cnt0 = tx_start_cnt;
        exp_q = {8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_dump(done_at);
        checks++;
        if (done_at != DUMP_CYCLES || tx_start_cnt - cnt0 != 8 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL spurious_send: done at %0d, %0d tx_starts, %0d left, required %0d / 8 / 0",
                     done_at, tx_start_cnt - cnt0, exp_q.size(), DUMP_CYCLES);
        end
        spur_send = 1'b0;
        $display("spurious tx_done checked");
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 2**ADDR_W; i++) mem[i] = '0;
        mem[0] = 32'h11223344;
        mem[1] = 32'hAABBCCDD;
        reset = 1'b1; dump_start = 1'b0; datapath_on = 1'b0;
        pipe_we = 4'h3; pipe_addr = 8'h5A; extra_done = 1'b0;

        test_reset();
        test_passthrough();
        test_first_byte_timing();
        test_full_dump();
        test_abort_in_rd();
        test_abort_in_txw();
        test_reset_mid_dump();
        test_spurious_tx_done();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d bytes left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
